// File: rtl/s_rca_arbiter_pkg.sv
// s_rca_arbiter_pkg
//   Types and helpers shared by the s_rca_arbiter slice.
//   Contents:
//     arb_state_t : result-register occupancy (ST_EMPTY / ST_FULL)
//     NREQ_MIN/MAX: supported requester-count range
//     id_width()  : width of a requester index for a given requester count
package s_rca_arbiter_pkg;

  // The result register is either empty or holds one valid result.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_t;

  localparam int NREQ_MIN = 2;
  localparam int NREQ_MAX = 16;

  // Never returns zero, so an index port always has at least one bit.
  function automatic int id_width(input int nreq);
    return (nreq <= 2) ? 1 : $clog2(nreq);
  endfunction

endpackage

// File: rtl/s_rca.sv
// s_rca
//   N-bit signed ripple-carry adder producing an N+1-bit result that
//   equals sign_extend(a) + sign_extend(b); the extra bit means the
//   result can never overflow.
//   Ports:
//     a   : in  [N-1:0] signed operand
//     b   : in  [N-1:0] signed operand
//     sum : out [N:0]   signed sum
module s_rca #(
  parameter int N = 4
) (
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  output logic signed [N:0]   sum
);

  logic [N:0] carry;

  assign carry[0] = 1'b0;

  // One full adder per bit, carry rippling from bit 0 upward.
  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_fa
      assign sum[i]     = a[i] ^ b[i] ^ carry[i];
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  endgenerate

  // Top bit is one more full adder fed with the replicated sign bits;
  // its carry out would only duplicate the sign, so it is dropped.
  assign sum[N] = a[N-1] ^ b[N-1] ^ carry[N];

endmodule

// File: rtl/s_rca_arbiter.sv
// s_rca_arbiter
//   Arbitrates NREQ requesters onto a single shared signed adder and
//   holds the result in a one-deep output register with valid/ready
//   handshaking. A new grant may be issued in the same cycle the held
//   result is drained, so back-to-back results flow without bubbles.
//
//   Build option:
//     S_RCA_ARB_RR_EN defined   -> round-robin arbitration with a pointer
//     S_RCA_ARB_RR_EN undefined -> fixed priority, lowest index wins
//
//   Ports:
//     clk       : in  clock, rising edge
//     rst       : in  asynchronous active-high reset
//     req_valid : in  [NREQ-1:0]   requester i presents an operand pair
//     req_ready : out [NREQ-1:0]   requester i accepted this cycle (one-hot or 0)
//     req_a     : in  [NREQ*N-1:0] operand a of requester i at [i*N +: N]
//     req_b     : in  [NREQ*N-1:0] operand b of requester i at [i*N +: N]
//     out_valid : out              result register holds a result
//     out_ready : in               consumer takes the result
//     out_sum   : out [N:0]        signed sum
//     out_id    : out [IDW-1:0]    requester that produced out_sum
module s_rca_arbiter
  import s_rca_arbiter_pkg::*;
#(
  parameter  int N    = 4,
  parameter  int NREQ = 4,
  localparam int IDW  = id_width(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*N-1:0]   req_a,
  input  logic [NREQ*N-1:0]   req_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N:0]          out_sum,
  output logic [IDW-1:0]      out_id
);

  arb_state_t             state;
  logic                   found;
  logic                   grant_ok;
  logic [IDW-1:0]         win_id;
  logic signed [N-1:0]    sel_a;
  logic signed [N-1:0]    sel_b;
  logic signed [N:0]      sel_sum;

`ifdef S_RCA_ARB_RR_EN
  logic [IDW-1:0]         ptr;

  // Round-robin search: scan all requesters starting at the pointer and
  // take the first one with a valid pair.
  always_comb begin : arb_search
    int idx;
    found  = 1'b0;
    win_id = '0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        win_id = IDW'(idx);
      end
    end
  end
`else
  // Fixed priority: the lowest-numbered valid requester wins.
  always_comb begin : arb_search
    found  = 1'b0;
    win_id = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[k]) begin
        found  = 1'b1;
        win_id = IDW'(k);
      end
    end
  end
`endif

  // A grant needs a winner and room in the result register; room exists
  // when empty, or when full and the consumer drains this same cycle.
  // Reset forces req_ready low so nothing is accepted while in reset.
  always_comb begin
    grant_ok  = !rst && found && ((state == ST_EMPTY) || out_ready);
    req_ready = grant_ok ? (NREQ'(1) << win_id) : '0;
  end

  // Only the winner's operands reach the shared adder. Selection depends
  // on req_valid/pointer alone, so req_ready never depends on the data.
  always_comb begin
    sel_a = req_a[int'(win_id)*N +: N];
    sel_b = req_b[int'(win_id)*N +: N];
  end

  s_rca #(
    .N (N)
  ) u_adder (
    .a   (sel_a),
    .b   (sel_b),
    .sum (sel_sum)
  );

  // Occupancy FSM plus result register. A grant always lands in the
  // register (covering both the empty fill and the drain-and-refill
  // case); a drain with no grant empties it. The held sum and id change
  // only on a grant, so they stay stable under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_id    <= '0;
`ifdef S_RCA_ARB_RR_EN
      ptr       <= '0;
`endif
    end else if (grant_ok) begin
      state     <= ST_FULL;
      out_valid <= 1'b1;
      out_sum   <= sel_sum;
      out_id    <= win_id;
`ifdef S_RCA_ARB_RR_EN
      if (int'(win_id) == NREQ - 1)
        ptr <= '0;
      else
        ptr <= win_id + IDW'(1);
`endif
    end else if ((state == ST_FULL) && out_ready) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/s_rca_arbiter.md
S_RCA_ARBITER -- requirements
Module: s_rca_arbiter

Interface
REQ-001 SHALL have parameter N, default 4: operand width in bits; signed two's complement.
REQ-002 SHALL have parameter NREQ, default 4: number of requesters, 2..16.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port req_valid, input, NREQ bits: bit i set = requester i presents an operand pair.
REQ-006 SHALL have port req_ready, output, NREQ bits: bit i set = requester i's pair is accepted this cycle.
REQ-007 SHALL have port req_a, input, NREQ*N bits: operand a of requester i at bits [i*N +: N].
REQ-008 SHALL have port req_b, input, NREQ*N bits: operand b of requester i at bits [i*N +: N].
REQ-009 SHALL have port out_valid, output, 1 bit: result register holds a valid result.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port out_sum, output, N+1 bits: signed sum.
REQ-012 SHALL have port out_id, output, clog2(NREQ) bits: index of the requester that produced out_sum.

Function
REQ-013 SHALL share exactly one N-bit signed ripple-carry adder instance among all requesters.
REQ-014 SHALL compute out_sum = sign_extend(a) + sign_extend(b) to N+1 bits; never overflows; range -2^N .. 2^N-2.
REQ-015 SHALL implement a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 SHALL grant when state is EMPTY, or when FULL and out_ready=1 in the same cycle (bubble-free drain-and-refill).
REQ-017 SHALL assert at most one req_ready bit per cycle: the arbitration winner among the set req_valid bits, and only when a grant is allowed.
REQ-018 SHALL make req_ready combinational from req_valid, state, out_ready and the priority pointer; req_ready SHALL NOT depend on req_a or req_b.
REQ-019 SHALL register the winner's sum and index into out_sum/out_id at the granting edge: one-cycle latency.
REQ-020 SHALL transition FULL->EMPTY when out_ready=1 and no request is granted; EMPTY->FULL on a grant; FULL stays FULL on a simultaneous drain and grant.
REQ-021 SHALL hold out_sum and out_id stable while out_valid=1 and out_ready=0.
REQ-022 SHALL hold all state while no req_valid bit is set, except for the drain transition in REQ-020.

Reset
REQ-023 SHALL on rst=1, immediately and regardless of clk: set state EMPTY, out_valid=0, out_sum=0, out_id=0, priority pointer=0.
REQ-024 SHALL discard a held result when rst is asserted mid-operation; req_ready SHALL be all-zero while rst=1.

Configuration
REQ-025 SHALL use round-robin arbitration when S_RCA_ARB_RR_EN is defined: search starts at the pointer; after a grant to i the pointer becomes (i+1) mod NREQ.
REQ-026 SHALL use fixed priority when S_RCA_ARB_RR_EN is undefined: the lowest set index wins, and no pointer register is present.

Structure
REQ-027 SHALL place the FSM state enum and the ID-width constant/function in package s_rca_arbiter_pkg.
REQ-028 SHALL instantiate sub-module s_rca (parameter N; inputs a, b; output N+1-bit signed sum) as the shared adder.

Verification (N=4, NREQ=4)
REQ-029 SHALL verify arithmetic extremes: req0 a=4'b1000, b=4'b1000 -> out_sum=5'b10000 (-16), out_id=0, one cycle later; a=7, b=7 -> out_sum=5'b01110.
REQ-030 SHALL verify round-robin with S_RCA_ARB_RR_EN defined: all req_valid=1 and out_ready=1 continuously -> out_id sequence 0,1,2,3,0, one result per cycle, no bubbles.
REQ-031 SHALL verify fixed priority without the macro: req_valid=4'b1001 and out_ready=1 continuously -> out_id=0 every cycle, req_ready[3] never set.
REQ-032 SHALL verify backpressure: result held and out_ready=0 for 5 cycles -> out_sum/out_id unchanged and req_ready=0; the first cycle with out_ready=1 grants the next requester.
REQ-033 SHALL verify reset mid-operation: rst pulsed between clock edges while FULL -> out_valid=0 and out_sum=0 before the next edge; after release the first grant goes to requester 0.
